serv_bufreg_seq: RTL and testbench

Sequencer for the bit-serial buffer register (W=1 or W=4) used for load/store address generation and shift data.
- Drives the bufreg control strobes en, init, cnt0, cnt1 and cnt_done through an init phase, a run phase and a data-bus phase.
- Checks load/store alignment from the bufreg LSBs and owns the dbus cyc/we handshake.
- Sits between the decoder (start/op) and serv_bufreg plus the dbus.

---
 rtl/serv_bufreg_pkg.sv | 29 ++
 rtl/serv_phase_cnt.sv | 45 ++++
 rtl/serv_bufreg_seq.sv | 132 +++++++++++++
 tb/tb_serv_bufreg_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serv_bufreg_pkg.sv
// Shared types and constants for the bufreg sequencer: state encoding, op/size codes
// and the phase length / counter width derived from the datapath width W.
package serv_bufreg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_BUS  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic int phase_len(input int w);
    return 32 / w;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(32 / w);
  endfunction

endpackage

// File: rtl/serv_phase_cnt.sv
// Phase counter: counts 0..P-1 while enabled and decodes first/second/last-cycle strobes.
// Strobes come from the registered count gated by i_en; no backpressure, clear wins over count.
module serv_phase_cnt
  import serv_bufreg_pkg::*;
#(
  parameter int W = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt_done
);

  localparam int CW = cnt_width(W);
  localparam int P  = phase_len(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt0     = i_en & (cnt_q == '0);
  assign o_cnt1     = i_en & (cnt_q == CNT_ONE);
  assign o_cnt_done = i_en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/serv_bufreg_seq.sv
// Bufreg sequencer: INIT then RUN (shift) or BUS (load/store), one-cycle FIN with done or trap.
// Outputs decode registered state only; the bus phase waits on i_dbus_ack for as long as needed.
module serv_bufreg_seq
  import serv_bufreg_pkg::*;
#(
  parameter int W = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic [1:0] i_size,
  input  logic [1:0] i_lsb,
  input  logic       i_dbus_ack,
  output logic       o_en,
  output logic       o_init,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt_done,
  output logic       o_dbus_cyc,
  output logic       o_dbus_we,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_trap
);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] size_q, size_d;
  logic       trap_q, trap_d;

  logic phase_act;
  logic cnt_clr;
  logic cnt_done;
  logic misalign;
  logic op_shift;

  assign phase_act = (state_q == ST_INIT) || (state_q == ST_RUN);
  // Reserved op 11 shares the shift path, so only the upper op bit matters.
  assign op_shift  = op_q[1];
  // Holding the counter clear in IDLE makes cnt0 land on the first INIT cycle.
  assign cnt_clr   = (state_q == ST_IDLE) || ((state_q == ST_INIT) && cnt_done);

  always_comb begin
    misalign = 1'b0;
    case (size_q)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = i_lsb[0];
      default: misalign = |i_lsb;
    endcase
  end

  serv_phase_cnt #(
    .W(W)
  ) u_phase_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (cnt_clr),
    .i_en       (phase_act),
    .o_cnt0     (o_cnt0),
    .o_cnt1     (o_cnt1),
    .o_cnt_done (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    trap_d  = trap_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          size_d  = i_size;
          trap_d  = 1'b0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (cnt_done) begin
          if (op_shift) begin
            state_d = ST_RUN;
          end else if (misalign) begin
            trap_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_BUS;
          end
        end
      end
      ST_RUN: begin
        if (cnt_done) begin
          state_d = ST_FIN;
        end
      end
      ST_BUS: begin
        if (i_dbus_ack) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        trap_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      size_q  <= 2'b00;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      trap_q  <= trap_d;
    end
  end

  assign o_en       = phase_act;
  assign o_init     = (state_q == ST_INIT);
  assign o_cnt_done = cnt_done;
  assign o_dbus_cyc = (state_q == ST_BUS);
  assign o_dbus_we  = (state_q == ST_BUS) && (op_q == OP_STORE);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_FIN) && !trap_q;
  assign o_trap     = (state_q == ST_FIN) && trap_q;

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Scoreboard bench for serv_bufreg_seq: W=1 and W=4 instances, directed operations push
// hand-computed (cycle, output vector) events that one negedge monitor pops and compares.
module tb_serv_bufreg_seq;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] STORE = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] WORD  = 2'b10;

  // Vector bits: en init cnt0 cnt1 cnt_done cyc we busy done trap
  localparam logic [9:0] V_I0 = 10'b11_100_00_100;
  localparam logic [9:0] V_I1 = 10'b11_010_00_100;
  localparam logic [9:0] V_ID = 10'b11_001_00_100;
  localparam logic [9:0] V_R0 = 10'b10_100_00_100;
  localparam logic [9:0] V_R1 = 10'b10_010_00_100;
  localparam logic [9:0] V_RD = 10'b10_001_00_100;
  localparam logic [9:0] V_BL = 10'b00_000_10_100;
  localparam logic [9:0] V_BS = 10'b00_000_11_100;
  localparam logic [9:0] V_DN = 10'b00_000_00_110;
  localparam logic [9:0] V_TR = 10'b00_000_00_101;
  localparam logic [9:0] V_ZZ = 10'b00_000_00_000;

  typedef struct packed {
    int         cyc;
    logic [9:0] v;
  } ev_t;

  logic clk = 1'b0;
  int   cycle_n = 0;
  int   checks = 0;
  int   passes = 0;
  logic fin_req = 1'b0;
  logic rst_checked = 1'b0;
  ev_t  q1[$];
  ev_t  q4[$];
  logic [9:0] p1 = '0;
  logic [9:0] p4 = '0;

  logic rst1_n = 1'b1, start1 = 1'b0, ack1 = 1'b0;
  logic [1:0] op1 = '0, size1 = '0, lsb1 = '0;
  logic en1, init1, c0_1, c1_1, cd1, cyc1, we1, busy1, done1, trap1;

  logic rst4_n = 1'b1, start4 = 1'b0, ack4 = 1'b0;
  logic [1:0] op4 = '0, size4 = '0, lsb4 = '0;
  logic en4, init4, c0_4, c1_4, cd4, cyc4, we4, busy4, done4, trap4;

  serv_bufreg_seq #(.W(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_start(start1), .i_op(op1), .i_size(size1),
    .i_lsb(lsb1), .i_dbus_ack(ack1), .o_en(en1), .o_init(init1), .o_cnt0(c0_1),
    .o_cnt1(c1_1), .o_cnt_done(cd1), .o_dbus_cyc(cyc1), .o_dbus_we(we1),
    .o_busy(busy1), .o_done(done1), .o_trap(trap1)
  );

  serv_bufreg_seq #(.W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_start(start4), .i_op(op4), .i_size(size4),
    .i_lsb(lsb4), .i_dbus_ack(ack4), .o_en(en4), .o_init(init4), .o_cnt0(c0_4),
    .o_cnt1(c1_4), .o_cnt_done(cd4), .o_dbus_cyc(cyc4), .o_dbus_we(we4),
    .o_busy(busy4), .o_done(done4), .o_trap(trap4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int c, input logic [9:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    if (idx == 0) q1.push_back(e);
    else          q4.push_back(e);
  endtask

  task automatic exp_init(input int idx, input int s);
    int p;
    p = (idx == 0) ? 32 : 8;
    push(idx, s + 1, V_I0);
    push(idx, s + 2, V_I1);
    push(idx, s + p, V_ID);
  endtask

  task automatic go1(input logic [1:0] op, input logic [1:0] sz, input logic [1:0] lsb, output int s);
    s = cycle_n;
    op1 = op; size1 = sz; lsb1 = lsb; start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
  endtask

  task automatic go4(input logic [1:0] op, input logic [1:0] sz, input logic [1:0] lsb, output int s);
    s = cycle_n;
    op4 = op; size4 = sz; lsb4 = lsb; start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
  endtask

  task automatic chk(input int idx, input logic [9:0] v);
    ev_t e;
    int  w;
    w = (idx == 0) ? 1 : 4;
    checks++;
    if ((idx == 0 && q1.size() == 0) || (idx != 0 && q4.size() == 0)) begin
      $display("FAIL event_w%0d: got cycle %0d vec %b, expected no event", w, cycle_n, v);
      return;
    end
    if (idx == 0) e = q1.pop_front();
    else          e = q4.pop_front();
    if (e.cyc != cycle_n || e.v != v)
      $display("FAIL event_w%0d: got cycle %0d vec %b, expected cycle %0d vec %b", w, cycle_n, v, e.cyc, e.v);
    else
      passes++;
  endtask

  function automatic logic trig(input logic [9:0] v, input logic [9:0] p);
    return v[7] | v[6] | v[5] | v[1] | v[0] | (v[4] != p[4]) | (v[3] != p[3]) | (v[2] != p[2]);
  endfunction

  always @(negedge clk) begin
    logic [9:0] v1, v4;
    v1 = {en1, init1, c0_1, c1_1, cd1, cyc1, we1, busy1, done1, trap1};
    v4 = {en4, init4, c0_4, c1_4, cd4, cyc4, we4, busy4, done4, trap4};
    if (!rst1_n && !rst4_n && !rst_checked) begin
      rst_checked = 1'b1;
      checks += 2;
      if (v1 != V_ZZ) $display("FAIL reset_w1: got %b, expected %b", v1, V_ZZ);
      else            passes++;
      if (v4 != V_ZZ) $display("FAIL reset_w4: got %b, expected %b", v4, V_ZZ);
      else            passes++;
    end
    if (trig(v1, p1)) chk(0, v1);
    if (trig(v4, p4)) chk(1, v4);
    p1 = v1;
    p4 = v4;
    if (fin_req || cycle_n > 3000) begin
      if (!fin_req) begin
        checks++;
        $display("FAIL timeout: got cycle %0d, expected stimulus done before 3000", cycle_n);
      end
      checks += 2;
      if (q1.size() != 0) $display("FAIL pending_w1: got %0d events left, expected 0", q1.size());
      else                passes++;
      if (q4.size() != 0) $display("FAIL pending_w4: got %0d events left, expected 0", q4.size());
      else                passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
    end
  end

  initial begin
    #1;
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    tick(3);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    fork
      begin : w1_seq
        int s, s2;
        tick(1);
        // load word, ack raised in cycle s+35
        go1(LOAD, WORD, 2'b00, s);
        exp_init(0, s);
        push(0, s + 33, V_BL); push(0, s + 36, V_DN); push(0, s + 37, V_ZZ);
        tick(34);
        ack1 = 1'b1;
        tick(1);
        ack1 = 1'b0;
        tick(2);
        // shift: INIT then RUN, never on the bus
        go1(SHIFT, WORD, 2'b00, s);
        exp_init(0, s);
        push(0, s + 33, V_R0); push(0, s + 34, V_R1); push(0, s + 64, V_RD);
        push(0, s + 65, V_DN); push(0, s + 66, V_ZZ);
        tick(66);
        // reset in cycle s+20 of a load, then a clean restart
        go1(LOAD, WORD, 2'b00, s);
        exp_init(0, s);
        q1.pop_back();
        push(0, s + 20, V_ZZ);
        tick(19);
        rst1_n = 1'b0;
        tick(3);
        rst1_n = 1'b1;
        tick(1);
        ack1 = 1'b1;
        go1(LOAD, WORD, 2'b00, s2);
        exp_init(0, s2);
        push(0, s2 + 33, V_BL); push(0, s2 + 34, V_DN); push(0, s2 + 35, V_ZZ);
        tick(35);
        ack1 = 1'b0;
      end
      begin : w4_seq
        int s, s2;
        tick(1);
        ack4 = 1'b1;
        // misaligned store half traps, back-to-back store word with ack tied high
        go4(STORE, HALF, 2'b01, s);
        exp_init(1, s);
        push(1, s + 9, V_TR);
        tick(9);
        push(1, s + 10, V_ZZ);
        go4(STORE, WORD, 2'b00, s2);
        exp_init(1, s2);
        push(1, s2 + 9, V_BS); push(1, s2 + 10, V_DN); push(1, s2 + 11, V_ZZ);
        tick(11);
        // shift with a stray start during RUN
        go4(SHIFT, WORD, 2'b00, s);
        exp_init(1, s);
        push(1, s + 9, V_R0); push(1, s + 10, V_R1); push(1, s + 16, V_RD);
        push(1, s + 17, V_DN); push(1, s + 18, V_ZZ);
        tick(11);
        op4 = LOAD; size4 = WORD; start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        tick(6);
        // aligned load half with a stray store start during BUS
        ack4 = 1'b0;
        go4(LOAD, HALF, 2'b10, s);
        exp_init(1, s);
        push(1, s + 9, V_BL); push(1, s + 13, V_DN); push(1, s + 14, V_ZZ);
        tick(9);
        op4 = STORE; size4 = WORD; start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        tick(1);
        ack4 = 1'b1;
        tick(1);
        ack4 = 1'b0;
        tick(2);
      end
    join
    tick(5);
    fin_req = 1'b1;
  end

endmodule
